// File: rtl/handshake_timer.sv
// handshake_timer: loadable down-counting timer, timer end of the
// enable/load/flag handshake with a controller FSM.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   enable      count enable (level); in DONE, low acknowledges expiry
//   load        load strobe, beats enable in every state
//   load_value  terminal count N captured on load
//   auto_reload mode captured on load (1 periodic, 0 one-shot)
//   flag        expiry indication (sticky in DONE, 1-cycle pulse periodic)
//   count       current count, registered
//   busy        high while in RUN, registered
module handshake_timer #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_value,
    input  logic              auto_reload,
    output logic              flag,
    output logic [DWIDTH-1:0] count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DWIDTH-1:0] ZERO = '0;
    localparam logic [DWIDTH-1:0] ONE  = {{(DWIDTH-1){1'b0}}, 1'b1};

    state_t            state;
    logic [DWIDTH-1:0] cnt_q;
    logic [DWIDTH-1:0] reload_q;
    logic              mode_q;
    logic              flag_q;
    logic              busy_q;

    logic              zero_load;
    logic              last_tick;

    assign zero_load = (load_value == ZERO);
    assign last_tick = (cnt_q == ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt_q    <= ZERO;
            reload_q <= ZERO;
            mode_q   <= 1'b0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (load) begin
            // A zero load expires at once in either mode.
            reload_q <= load_value;
            cnt_q    <= load_value;
            mode_q   <= auto_reload;
            if (zero_load) begin
                state  <= DONE;
                flag_q <= 1'b1;
                busy_q <= 1'b0;
            end else begin
                state  <= RUN;
                flag_q <= 1'b0;
                busy_q <= 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    flag_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                RUN: begin
                    // The only time flag is high in RUN is the cycle
                    // after a periodic pulse, so clearing it here
                    // drops the pulse regardless of enable.
                    flag_q <= 1'b0;
                    busy_q <= 1'b1;
                    if (enable) begin
                        if (last_tick) begin
                            flag_q <= 1'b1;
                            if (mode_q) begin
                                cnt_q <= reload_q;
                            end else begin
                                cnt_q  <= ZERO;
                                state  <= DONE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    if (enable) begin
                        flag_q <= 1'b1;
                    end else begin
                        flag_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    flag_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign flag  = flag_q;
    assign count = cnt_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_handshake_timer.sv
// tb_handshake_timer: directed self-checking bench for handshake_timer.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_handshake_timer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic       auto_reload;
    logic       flag;
    logic [7:0] count;
    logic       busy;

    int n_chk;
    int n_pass;

    handshake_timer #(.DWIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .auto_reload(auto_reload),
        .flag       (flag),
        .count      (count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int c,
                        input int f, input int b);
        chk({tag, ".count"}, count, c);
        chk({tag, ".flag"}, flag, f);
        chk({tag, ".busy"}, busy, b);
    endtask

    task automatic do_load(input int v, input logic ar);
        load        = 1'b1;
        load_value  = v[7:0];
        auto_reload = ar;
        step();
        load        = 1'b0;
    endtask

    int pc[10];
    int pf[10];

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        enable = 1'b0;
        load = 1'b0;
        load_value = 8'd0;
        auto_reload = 1'b0;
        step();
        step();
        outs("reset", 0, 0, 0);
        rst = 1'b0;

        // one-shot 5, enable high, load beats enable
        enable = 1'b1;
        do_load(5, 1'b0);
        outs("os5_load", 5, 0, 1);
        for (int j = 1; j <= 4; j++) begin
            step();
            outs($sformatf("os5_j%0d", j), 5 - j, 0, 1);
        end
        step();
        outs("os5_exp", 0, 1, 0);
        step();
        outs("os5_sticky", 0, 1, 0);

        // acknowledge, then idle ignores enable
        enable = 1'b0;
        step();
        outs("ack", 0, 0, 0);
        enable = 1'b1;
        step();
        outs("idle_en", 0, 0, 0);

        // load 4 with a 3-cycle pause at count 2
        do_load(4, 1'b0);
        outs("p4_load", 4, 0, 1);
        step();
        outs("p4_j1", 3, 0, 1);
        step();
        outs("p4_j2", 2, 0, 1);
        enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            outs($sformatf("p4_hold%0d", j), 2, 0, 1);
        end
        enable = 1'b1;
        step();
        outs("p4_j6", 1, 0, 1);
        step();
        outs("p4_exp", 0, 1, 0);
        enable = 1'b0;
        step();
        outs("p4_ack", 0, 0, 0);

        // periodic 3
        pc = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
        pf = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        enable = 1'b1;
        do_load(3, 1'b1);
        outs("per_load", 3, 0, 1);
        for (int j = 1; j <= 9; j++) begin
            step();
            outs($sformatf("per_j%0d", j), pc[j-1], pf[j-1], 1);
        end
        // pulse drops even with enable low
        enable = 1'b0;
        step();
        outs("per_drop", 3, 0, 1);

        // zero load, then load 6 from DONE with enable high
        enable = 1'b1;
        do_load(0, 1'b0);
        outs("z_load", 0, 1, 0);
        step();
        outs("z_sticky", 0, 1, 0);
        do_load(6, 1'b0);
        outs("l6_done", 6, 0, 1);
        step();
        outs("l6_j1", 5, 0, 1);

        // reload mid-run
        do_load(8, 1'b0);
        outs("r8_load", 8, 0, 1);
        for (int j = 1; j <= 3; j++) begin
            step();
            outs($sformatf("r8_j%0d", j), 8 - j, 0, 1);
        end
        do_load(2, 1'b0);
        outs("r2_load", 2, 0, 1);
        step();
        outs("r2_j1", 1, 0, 1);
        step();
        outs("r2_exp", 0, 1, 0);
        do_load(7, 1'b0);
        outs("r7_done", 7, 0, 1);

        // async reset mid-count at 3
        for (int j = 1; j <= 4; j++) step();
        outs("pre_rst", 3, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        outs("async_rst", 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        outs("post_en1", 0, 0, 0);
        step();
        outs("post_en2", 0, 0, 0);
        do_load(2, 1'b0);
        outs("post_load", 2, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
